qspi_multilane_slave: RTL and testbench

//  Memory-mapped SPI slave with a selectable data-phase lane width: x1, x2 or x4, chosen per transaction by the opcode.

---
 rtl/qspi_slave_pkg.sv | 39 +++
 rtl/qspi_pin_sync.sv | 32 +++
 rtl/qspi_multilane_slave.sv | 256 +++++++++++++++++++++++++
 tb/tb_qspi_multilane_slave.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_slave_pkg.sv
// Shared opcodes, FSM states and lane-width helpers
// for the multi-lane (Q)SPI register slave.
package qspi_slave_pkg;

    localparam logic [7:0] OP_W1 = 8'h02;
    localparam logic [7:0] OP_R1 = 8'h03;
    localparam logic [7:0] OP_W2 = 8'h3A;
    localparam logic [7:0] OP_R2 = 8'h3B;
    localparam logic [7:0] OP_W4 = 8'h32;
    localparam logic [7:0] OP_R4 = 8'h6B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_DUMMY,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    typedef enum logic [1:0] {
        LANE_X1,
        LANE_X2,
        LANE_X4
    } lane_t;

    function automatic logic [3:0] oe_mask(input lane_t m);
        logic [3:0] r;
        unique case (m)
            LANE_X1: r = 4'b0010;
            LANE_X2: r = 4'b0011;
            LANE_X4: r = 4'b1111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qspi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin,
// with rise/fall pulses on the synchronised level.
module qspi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // shift the pin through the chain; keep one more flop for edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/qspi_multilane_slave.sv
// Memory-mapped SPI slave, x1/x2/x4 data lanes chosen by opcode,
// all pins oversampled in the main_clock domain.
module qspi_multilane_slave
    import qspi_slave_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int DUMMY_CYCLES = 2
) (
    input  logic              main_clock,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              cs,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    output logic              write_data_flag,
    input  logic [DATA_W-1:0] read_data,
    output logic              read_data_flag,
    output logic              cmd_error
);

    localparam int MAXW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int SW   = (MAXW > 8) ? MAXW : 8;

    state_t state, state_n;
    lane_t  mode, ln, op_mode;

    logic sck_s, sck_rise, sck_fall;
    logic cs_s, cs_rise, cs_fall;
    logic unused_cs;

    logic [3:0]        io_chain [SYNC_STAGES];
    logic [3:0]        io_s;
    logic [CW-1:0]     cnt, cpw;
    logic [SW-1:0]     sin, sin_next;
    logic [DATA_W-1:0] sh, sh_shift;
    logic [3:0]        chunk;
    logic [7:0]        cmd_word;
    logic              rd, op_rd, op_ok;
    logic              load_pend, incr_pend;
    logic              cmd_last, addr_last, word_last;
    logic              dummy_last, chunk_last, drive;

    qspi_pin_sync #(.STAGES(SYNC_STAGES)) u_sck (
        .clk  (main_clock),
        .rst_n(rst_n),
        .d    (sck),
        .q    (sck_s),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    qspi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs (
        .clk  (main_clock),
        .rst_n(rst_n),
        .d    (cs),
        .q    (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    assign unused_cs = cs_rise ^ cs_fall ^ sck_s;

    // data pins only need the plain synchroniser chain
    always_ff @(posedge main_clock) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) io_chain[i] <= '0;
        end else begin
            io_chain[0] <= io_in;
            for (int i = 1; i < SYNC_STAGES; i++) io_chain[i] <= io_chain[i-1];
        end
    end

    assign io_s = io_chain[SYNC_STAGES-1];

    // shift-in/out helpers, lane counts and opcode decode
    always_comb begin
        ln = (state == ST_WDATA) ? mode : LANE_X1;
        unique case (ln)
            LANE_X2: sin_next = SW'({sin, io_s[1:0]});
            LANE_X4: sin_next = SW'({sin, io_s});
            default: sin_next = SW'({sin, io_s[0]});
        endcase
        unique case (mode)
            LANE_X2: begin
                cpw      = CW'(DATA_W / 2);
                chunk    = {2'b00, sh[DATA_W-1 -: 2]};
                sh_shift = sh << 2;
            end
            LANE_X4: begin
                cpw      = CW'(DATA_W / 4);
                chunk    = sh[DATA_W-1 -: 4];
                sh_shift = sh << 4;
            end
            default: begin
                cpw      = CW'(DATA_W);
                chunk    = {2'b00, sh[DATA_W-1], 1'b0};
                sh_shift = sh << 1;
            end
        endcase
        cmd_word = 8'(sin_next);
        op_ok    = 1'b1;
        op_rd    = 1'b0;
        op_mode  = LANE_X1;
        unique case (1'b1)
            cmd_word == OP_W1: op_mode = LANE_X1;
            cmd_word == OP_R1: op_rd = 1'b1;
            cmd_word == OP_W2: op_mode = LANE_X2;
            cmd_word == OP_R2: begin
                op_mode = LANE_X2;
                op_rd   = 1'b1;
            end
            cmd_word == OP_W4: op_mode = LANE_X4;
            cmd_word == OP_R4: begin
                op_mode = LANE_X4;
                op_rd   = 1'b1;
            end
            default: op_ok = 1'b0;
        endcase
        cmd_last   = (cnt == CW'(7));
        addr_last  = (cnt == CW'(ADDR_W - 1));
        word_last  = (cnt == cpw - CW'(1));
        dummy_last = (cnt == CW'(DUMMY_CYCLES));
        chunk_last = (state == ST_DUMMY) ? (cpw == CW'(1)) : word_last;
        drive      = sck_fall && ((state == ST_RDATA) ||
                                  (state == ST_DUMMY && dummy_last));
    end

    // FSM state register
    always_ff @(posedge main_clock) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // next state and pad enables; a deasserted cs always wins
    always_comb begin
        state_n = state;
        io_oe   = (state == ST_RDATA) ? oe_mask(mode) : 4'b0000;
        if (cs_s) begin
            state_n = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: state_n = ST_CMD;
                ST_CMD: begin
                    if (sck_rise && cmd_last)
                        state_n = op_ok ? ST_ADDR : ST_IGNORE;
                end
                ST_ADDR: begin
                    if (sck_rise && addr_last)
                        state_n = rd ? ST_DUMMY : ST_WDATA;
                end
                ST_DUMMY: begin
                    if (drive) state_n = ST_RDATA;
                end
                default: state_n = state;
            endcase
        end
    end

    // datapath: shift registers, bit counter, address and strobes
    always_ff @(posedge main_clock) begin
        if (!rst_n) begin
            io_out          <= '0;
            addr            <= '0;
            write_data      <= '0;
            write_data_flag <= 1'b0;
            read_data_flag  <= 1'b0;
            cmd_error       <= 1'b0;
            cnt             <= '0;
            sin             <= '0;
            sh              <= '0;
            mode            <= LANE_X1;
            rd              <= 1'b0;
            load_pend       <= 1'b0;
            incr_pend       <= 1'b0;
        end else begin
            write_data_flag <= 1'b0;
            read_data_flag  <= 1'b0;
            cmd_error       <= 1'b0;
            incr_pend       <= 1'b0;
            load_pend       <= read_data_flag;
            if (incr_pend) addr <= addr + ADDR_W'(1);
            if (load_pend) sh <= read_data;
            if (cs_s) begin
                cnt    <= '0;
                io_out <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: cnt <= '0;
                    ST_CMD: begin
                        if (sck_rise) begin
                            sin <= sin_next;
                            if (cmd_last) begin
                                cnt <= '0;
                                if (op_ok) begin
                                    mode <= op_mode;
                                    rd   <= op_rd;
                                end else begin
                                    cmd_error <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            sin <= sin_next;
                            if (addr_last) begin
                                cnt            <= '0;
                                addr           <= ADDR_W'(sin_next);
                                read_data_flag <= rd;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sck_rise) begin
                            sin <= sin_next;
                            if (word_last) begin
                                cnt             <= '0;
                                write_data      <= DATA_W'(sin_next);
                                write_data_flag <= 1'b1;
                                incr_pend       <= 1'b1;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sck_fall && !dummy_last) cnt <= cnt + CW'(1);
                    end
                    default: ;
                endcase
                if (drive) begin
                    io_out <= chunk;
                    sh     <= sh_shift;
                    if (chunk_last) begin
                        cnt            <= '0;
                        addr           <= addr + ADDR_W'(1);
                        read_data_flag <= 1'b1;
                    end else begin
                        cnt <= (state == ST_DUMMY) ? CW'(1) : cnt + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_qspi_multilane_slave.sv
// Directed bench for qspi_multilane_slave: x1/x2/x4 writes,
// reads with dummy cycles, wrap, bad opcode, cs abort, reset.
module tb_qspi_multilane_slave;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic [3:0] io_in = 4'h0;
    logic [3:0] io_out, io_oe;
    logic [7:0] addr, write_data, read_data;
    logic       write_data_flag, read_data_flag, cmd_error;

    logic [7:0]  mem [256];
    logic [15:0] wq [$];
    logic [7:0]  rq [$];
    int          ecnt = 0;
    int          excl = 0;
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  oe_acc;
    logic [3:0]  so [12];
    logic [3:0]  se [12];

    qspi_multilane_slave dut (
        .main_clock     (clk),
        .rst_n          (rst_n),
        .sck            (sck),
        .cs             (cs),
        .io_in          (io_in),
        .io_out         (io_out),
        .io_oe          (io_oe),
        .addr           (addr),
        .write_data     (write_data),
        .write_data_flag(write_data_flag),
        .read_data      (read_data),
        .read_data_flag (read_data_flag),
        .cmd_error      (cmd_error)
    );

    always #5 clk = ~clk;

    assign read_data = mem[addr];

    always @(negedge clk) begin
        if (rst_n) begin
            if (write_data_flag) wq.push_back({addr, write_data});
            if (read_data_flag) rq.push_back(addr);
            if (cmd_error) ecnt++;
            if (int'(write_data_flag) + int'(read_data_flag) + int'(cmd_error) > 1)
                excl++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] wq_at(input int i);
        return (i < wq.size()) ? wq[i] : 16'hDEAD;
    endfunction

    function automatic logic [7:0] rq_at(input int i);
        return (i < rq.size()) ? rq[i] : 8'hEE;
    endfunction

    task automatic sck_bit(input logic [3:0] v, output logic [3:0] o,
                           output logic [3:0] e);
        @(negedge clk);
        io_in = v;
        repeat (HALF) @(negedge clk);
        o = io_out;
        e = io_oe;
        oe_acc = oe_acc | io_oe;
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic start_cs();
        wq.delete();
        rq.delete();
        oe_acc = 4'h0;
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic end_cs();
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int lanes, input int n);
        logic [3:0] o, e;
        for (int i = 0; i < n; i++) begin
            unique case (lanes)
                2:       sck_bit({2'b00, b[7-2*i -: 2]}, o, e);
                4:       sck_bit(b[7-4*i -: 4], o, e);
                default: sck_bit({3'b000, b[7-i]}, o, e);
            endcase
        end
    endtask

    task automatic read_cycles(input int n);
        for (int i = 0; i < n; i++) sck_bit(4'h0, so[i], se[i]);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h40] = 8'hAB;
        mem[8'hFF] = 8'h96;
        mem[8'h00] = 8'h5C;
        oe_acc = 4'h0;
        repeat (4) @(negedge clk);
        check("reset_out", {io_out, io_oe, addr, write_data, write_data_flag,
              read_data_flag, cmd_error}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // x2 write burst
        start_cs();
        send(8'h3A, 1, 8);
        send(8'hAB, 1, 8);
        send(8'hCD, 2, 4);
        send(8'h53, 2, 4);
        end_cs();
        check("t1_nwr", wq.size(), 2);
        check("t1_w0", wq_at(0), 16'hABCD);
        check("t1_w1", wq_at(1), 16'hAC53);
        check("t1_err", ecnt, 0);
        check("t1_addr", addr, 8'hAD);

        // x4 write burst
        start_cs();
        send(8'h32, 1, 8);
        send(8'h10, 1, 8);
        send(8'h12, 4, 2);
        send(8'h34, 4, 2);
        end_cs();
        check("t2_nwr", wq.size(), 2);
        check("t2_w0", wq_at(0), 16'h1012);
        check("t2_w1", wq_at(1), 16'h1134);
        check("t2_oe", oe_acc, 4'h0);

        // x4 read with two dummy cycles
        start_cs();
        send(8'h6B, 1, 8);
        send(8'h40, 1, 8);
        read_cycles(4);
        end_cs();
        check("t3_d0", {so[0], se[0]}, 8'h00);
        check("t3_d1", {so[1], se[1]}, 8'h00);
        check("t3_c0", {so[2], se[2]}, 8'hAF);
        check("t3_c1", {so[3], se[3]}, 8'hBF);
        check("t3_nrd", rq.size(), 2);
        check("t3_f0", rq_at(0), 8'h40);
        check("t3_f1", rq_at(1), 8'h41);

        // x2 read across address wrap
        start_cs();
        send(8'h3B, 1, 8);
        send(8'hFF, 1, 8);
        read_cycles(10);
        end_cs();
        check("t4_d", {se[0], se[1]}, 8'h00);
        check("t4_w0", {so[2], so[3], so[4], so[5]}, 16'h2112);
        check("t4_w1", {so[6], so[7], so[8], so[9]}, 16'h1130);
        check("t4_oe", {se[2], se[5], se[9]}, 12'h333);
        check("t4_f0", rq_at(0), 8'hFF);
        check("t4_f1", rq_at(1), 8'h00);
        check("t4_nrd", rq.size(), 3);

        // unknown opcode, then a normal x1 write
        ecnt = 0;
        start_cs();
        send(8'hFF, 1, 8);
        send(8'h02, 1, 8);
        send(8'h55, 1, 8);
        end_cs();
        check("t5_err", ecnt, 1);
        check("t5_quiet", wq.size() + rq.size(), 0);
        check("t5_oe", oe_acc, 4'h0);
        start_cs();
        send(8'h02, 1, 8);
        send(8'h05, 1, 8);
        send(8'h77, 1, 8);
        end_cs();
        check("t5_nwr", wq.size(), 1);
        check("t5_w0", wq_at(0), 16'h0577);
        check("t5_err2", ecnt, 1);

        // partial word aborted by cs
        start_cs();
        send(8'h02, 1, 8);
        send(8'h20, 1, 8);
        send(8'hA0, 1, 4);
        end_cs();
        check("t6_nwr", wq.size(), 0);
        check("t6_oe", io_oe, 4'h0);

        // reset in the middle of a read data phase
        start_cs();
        send(8'h6B, 1, 8);
        send(8'h40, 1, 8);
        read_cycles(4);
        check("t6_rd_oe", se[3], 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst", {io_out, io_oe, addr, write_data, write_data_flag,
              read_data_flag, cmd_error}, 0);
        cs = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        check("excl", excl, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
